// File: rtl/fetch_pkg.sv
// Shared widths, ROM geometry and FSM encoding for the instruction fetch stage.
package fetch_pkg;
  localparam int ADDR_W    = 8;
  localparam int INSTR_W   = 8;
  localparam int ROM_DEPTH = 32;

  localparam logic [ADDR_W-1:0] PC_RESET = '0;
  localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM port, decoder valid/ready port and control requests.
interface fetch_unit_if
  import fetch_pkg::*;
  ();
  logic               en;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump_valid;
  logic [ADDR_W-1:0]  jump_addr;
  logic               halt_req;
  logic               halted;
  logic               addr_err;

  modport master (
    input  en, rom_data, instr_ready, jump_valid, jump_addr, halt_req,
    output rom_addr, instr_out, instr_pc, instr_valid, halted, addr_err
  );

  modport slave (
    output en, rom_data, instr_ready, jump_valid, jump_addr, halt_req,
    input  rom_addr, instr_out, instr_pc, instr_valid, halted, addr_err
  );
endinterface

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output register holding an instruction and its fetch address.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_ready,
  input  logic [INSTR_W-1:0] i_data,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic [INSTR_W-1:0] o_data,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid
);
  logic [INSTR_W-1:0] r_data;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;

  // NOTE: state updates use <= so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_pc    <= PC_RESET;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IDLE/FETCH/HALT control and the decoder-facing output register.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.master bus
);
  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic              r_addr_err;
  logic              w_jump_oob;
  logic              w_load;
  logic              w_halted;
  logic              w_valid;

  assign w_jump_oob = bus.jump_addr >= ADDR_W'(ROM_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.en) w_state_next = FETCH;
      FETCH: begin
        if (bus.halt_req)        w_state_next = HALT;
        else if (bus.jump_valid) w_state_next = FETCH;
        else if (!bus.en)        w_state_next = IDLE;
      end
      HALT:    if (bus.jump_valid) w_state_next = FETCH;
      default: w_state_next = IDLE;
    endcase
  end

  // A jump, halt or disable all suppress the load; the jump itself flushes the output.
  always_comb begin
    w_load   = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      FETCH:   w_load = bus.en && !bus.halt_req && !bus.jump_valid &&
                        (!w_valid || bus.instr_ready);
      HALT:    w_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= PC_RESET;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= bus.jump_valid && w_jump_oob;
      if (bus.jump_valid)
        r_pc <= w_jump_oob ? PC_RESET : bus.jump_addr;
      else if (w_load)
        r_pc <= (r_pc == PC_LAST) ? PC_RESET : r_pc + ADDR_W'(1);
    end
  end

  fetch_out_reg u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_flush (bus.jump_valid),
    .i_ready (bus.instr_ready),
    .i_data  (bus.rom_data),
    .i_pc    (r_pc),
    .o_data  (bus.instr_out),
    .o_pc    (bus.instr_pc),
    .o_valid (w_valid)
  );

  assign bus.rom_addr    = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.halted      = w_halted;
  assign bus.addr_err    = r_addr_err;
endmodule
